// File: rtl/ddr_rw_arbiter.sv
// Four-client round-robin arbiter in front of DDR write/read controllers.
// Clients 0-1 drive the write controller; clients 2-3 drive the read controller.
module ddr_rw_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LEN_W  = 4,
    parameter int TMO    = 15
) (
    input  logic                  clk_100M,
    input  logic                  rstn,
    input  logic                  init_done,
    input  logic [3:0]            cli_req,
    input  logic [4*ADDR_W-1:0]   cli_addr,
    input  logic [4*LEN_W-1:0]    cli_len,
    output logic [3:0]            cli_gnt,
    output logic [3:0]            cli_done,
    output logic [3:0]            cli_err,
    output logic                  wr_req,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [LEN_W-1:0]      wr_len,
    input  logic                  wr_busy,
    output logic                  rd_req,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic [LEN_W-1:0]      rd_len,
    input  logic                  rd_busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(TMO - 1);

    state_t            state, state_d;
    logic [1:0]        last, last_d;
    logic [1:0]        idx, idx_d;
    logic [3:0]        cnt, cnt_d;
    logic [1:0]        pick, cand;
    logic              found;
    logic              busy_m;
    logic [3:0]        gnt_d, done_d, err_d;
    logic              wr_req_d, rd_req_d;
    logic [ADDR_W-1:0] wr_addr_d, rd_addr_d;
    logic [LEN_W-1:0]  wr_len_d, rd_len_d;

    // Controller busy for the transaction in flight (idx[1] marks a read client).
    assign busy_m = idx[1] ? rd_busy : wr_busy;

    // Round-robin search starting just after the last completed client.
    always_comb begin
        found = 1'b0;
        pick  = last;
        cand  = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && cli_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        last_d    = last;
        idx_d     = idx;
        cnt_d     = cnt;
        gnt_d     = cli_gnt;
        done_d    = '0;
        err_d     = '0;
        wr_req_d  = wr_req;
        rd_req_d  = rd_req;
        wr_addr_d = wr_addr;
        wr_len_d  = wr_len;
        rd_addr_d = rd_addr;
        rd_len_d  = rd_len;
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (init_done && found) begin
                    idx_d   = pick;
                    gnt_d   = 4'b0001 << pick;
                    state_d = WAIT_BUSY;
                    if (pick[1]) begin
                        rd_req_d  = 1'b1;
                        rd_addr_d = cli_addr[int'(pick)*ADDR_W +: ADDR_W];
                        rd_len_d  = cli_len[int'(pick)*LEN_W +: LEN_W];
                    end else begin
                        wr_req_d  = 1'b1;
                        wr_addr_d = cli_addr[int'(pick)*ADDR_W +: ADDR_W];
                        wr_len_d  = cli_len[int'(pick)*LEN_W +: LEN_W];
                    end
                end
            end
            WAIT_BUSY: begin
                if (busy_m) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    state_d  = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    wr_req_d = 1'b0;
                    rd_req_d = 1'b0;
                    err_d    = cli_gnt;
                    gnt_d    = '0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            WAIT_DONE: begin
                if (!busy_m) begin
                    done_d  = cli_gnt;
                    gnt_d   = '0;
                    last_d  = idx;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d    = '0;
                wr_req_d = 1'b0;
                rd_req_d = 1'b0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk_100M) begin
        if (!rstn) begin
            state    <= IDLE;
            last     <= 2'd3;
            idx      <= '0;
            cnt      <= '0;
            cli_gnt  <= '0;
            cli_done <= '0;
            cli_err  <= '0;
            wr_req   <= 1'b0;
            rd_req   <= 1'b0;
            wr_addr  <= '0;
            wr_len   <= '0;
            rd_addr  <= '0;
            rd_len   <= '0;
        end else begin
            state    <= state_d;
            last     <= last_d;
            idx      <= idx_d;
            cnt      <= cnt_d;
            cli_gnt  <= gnt_d;
            cli_done <= done_d;
            cli_err  <= err_d;
            wr_req   <= wr_req_d;
            rd_req   <= rd_req_d;
            wr_addr  <= wr_addr_d;
            wr_len   <= wr_len_d;
            rd_addr  <= rd_addr_d;
            rd_len   <= rd_len_d;
        end
    end

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Bench for ddr_rw_arbiter: vector table, directed corner cases and
// random traffic against a transaction-level reference model.
module tb_ddr_rw_arbiter;

    localparam int AW  = 28;
    localparam int LW  = 4;
    localparam int TMO = 15;

    logic              clk_100M = 1'b0;
    logic              rstn = 1'b0;
    logic              init_done = 1'b0;
    logic [3:0]        cli_req = '0;
    logic [4*AW-1:0]   cli_addr = '0;
    logic [4*LW-1:0]   cli_len = '0;
    logic [3:0]        cli_gnt, cli_done, cli_err;
    logic              wr_req, rd_req;
    logic [AW-1:0]     wr_addr, rd_addr;
    logic [LW-1:0]     wr_len, rd_len;
    logic              wr_busy = 1'b0;
    logic              rd_busy = 1'b0;

    int errs = 0;
    int checks = 0;

    ddr_rw_arbiter #(.ADDR_W(AW), .LEN_W(LW), .TMO(TMO)) dut (
        .clk_100M(clk_100M), .rstn(rstn), .init_done(init_done),
        .cli_req(cli_req), .cli_addr(cli_addr), .cli_len(cli_len),
        .cli_gnt(cli_gnt), .cli_done(cli_done), .cli_err(cli_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_busy(wr_busy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_busy(rd_busy)
    );

    always #5 clk_100M = ~clk_100M;

    // Reference model: one outstanding transaction owned by a client index.
    int            owner = -1;
    bit            acked = 0;
    int            waited = 0;
    int            last_m = 3;
    logic [3:0]    m_done = '0, m_err = '0;
    logic          m_wr_req = 0, m_rd_req = 0;
    logic [AW-1:0] m_wr_addr = '0, m_rd_addr = '0;
    logic [LW-1:0] m_wr_len = '0, m_rd_len = '0;

    task automatic model_edge();
        bit busy;
        m_done = '0;
        m_err  = '0;
        if (!rstn) begin
            owner = -1; acked = 0; waited = 0; last_m = 3;
            m_wr_req = 0; m_rd_req = 0;
            m_wr_addr = '0; m_rd_addr = '0; m_wr_len = '0; m_rd_len = '0;
        end else if (owner < 0) begin
            if (init_done && cli_req != 0) begin
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (last_m + k) % 4;
                    if (cli_req[c]) begin
                        owner = c;
                        break;
                    end
                end
                acked = 0;
                waited = 0;
                if (owner < 2) begin
                    m_wr_req = 1;
                    m_wr_addr = cli_addr[owner*AW +: AW];
                    m_wr_len = cli_len[owner*LW +: LW];
                end else begin
                    m_rd_req = 1;
                    m_rd_addr = cli_addr[owner*AW +: AW];
                    m_rd_len = cli_len[owner*LW +: LW];
                end
            end
        end else begin
            busy = (owner < 2) ? wr_busy : rd_busy;
            if (!acked) begin
                if (busy) begin
                    acked = 1;
                    m_wr_req = 0;
                    m_rd_req = 0;
                end else begin
                    waited++;
                    if (waited == TMO) begin
                        m_wr_req = 0;
                        m_rd_req = 0;
                        m_err[owner] = 1'b1;
                        owner = -1;
                    end
                end
            end else if (!busy) begin
                m_done[owner] = 1'b1;
                last_m = owner;
                owner = -1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_gnt();
        return (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
    endfunction

    // Advance one clock: model follows the edge, outputs checked 1 ns later.
    task automatic step();
        @(posedge clk_100M);
        model_edge();
        #1;
        chk("model", {cli_gnt, cli_done, cli_err, wr_req, rd_req,
                      wr_addr, wr_len, rd_addr, rd_len},
                     {m_gnt(), m_done, m_err, m_wr_req, m_rd_req,
                      m_wr_addr, m_wr_len, m_rd_addr, m_rd_len});
        chk("onehot", 128'($countones(cli_gnt) <= 1), 128'(1));
    endtask

    typedef struct {
        logic       rstn;
        logic       init;
        logic [3:0] req;
        logic       wb;
        logic       rb;
        logic [3:0] gnt;
        logic       wreq;
        logic       rreq;
        logic [3:0] done;
        logic [3:0] err;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(logic r, logic i, logic [3:0] q, logic wb,
                                logic rb, logic [3:0] g, logic wq, logic rq,
                                logic [3:0] d, logic [3:0] e);
        vec_t v;
        v.rstn = r; v.init = i; v.req = q; v.wb = wb; v.rb = rb;
        v.gnt = g; v.wreq = wq; v.rreq = rq; v.done = d; v.err = e;
        return v;
    endfunction

    int hi;

    initial begin
        tbl[0]  = mk(0, 0, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[1]  = mk(1, 0, 4'b0011, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[2]  = mk(1, 0, 4'b0011, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[3]  = mk(1, 1, 4'b0011, 0, 0, 4'b0001, 1, 0, 4'b0000, 4'b0000);
        tbl[4]  = mk(1, 1, 4'b0000, 1, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000);
        tbl[5]  = mk(1, 1, 4'b0000, 1, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000);
        tbl[6]  = mk(1, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0001, 4'b0000);
        tbl[7]  = mk(1, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        tbl[8]  = mk(1, 1, 4'b1111, 0, 0, 4'b0010, 1, 0, 4'b0000, 4'b0000);
        tbl[9]  = mk(1, 1, 4'b1111, 1, 0, 4'b0010, 0, 0, 4'b0000, 4'b0000);
        tbl[10] = mk(1, 1, 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0010, 4'b0000);
        tbl[11] = mk(1, 1, 4'b1111, 0, 0, 4'b0100, 0, 1, 4'b0000, 4'b0000);
        tbl[12] = mk(1, 1, 4'b1111, 0, 1, 4'b0100, 0, 0, 4'b0000, 4'b0000);
        tbl[13] = mk(1, 1, 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0100, 4'b0000);
        tbl[14] = mk(1, 1, 4'b1111, 0, 0, 4'b1000, 0, 1, 4'b0000, 4'b0000);
        tbl[15] = mk(1, 1, 4'b1111, 0, 1, 4'b1000, 0, 0, 4'b0000, 4'b0000);
        tbl[16] = mk(1, 1, 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b1000, 4'b0000);
        tbl[17] = mk(1, 1, 4'b1111, 0, 0, 4'b0001, 1, 0, 4'b0000, 4'b0000);
        tbl[18] = mk(1, 1, 4'b1111, 1, 0, 4'b0001, 0, 0, 4'b0000, 4'b0000);
        tbl[19] = mk(1, 1, 4'b1111, 0, 0, 4'b0000, 0, 0, 4'b0001, 4'b0000);

        for (int i = 0; i < 4; i++) begin
            cli_addr[i*AW +: AW] = AW'((i + 1) * 'h100);
            cli_len[i*LW +: LW]  = LW'(i + 5);
        end

        @(posedge clk_100M);
        #1;
        // Vector table: init gating, single write, round-robin contention.
        for (int i = 0; i < 20; i++) begin
            rstn = tbl[i].rstn; init_done = tbl[i].init; cli_req = tbl[i].req;
            wr_busy = tbl[i].wb; rd_busy = tbl[i].rb;
            step();
            chk($sformatf("tbl%0d", i), {cli_gnt, wr_req, rd_req, cli_done, cli_err},
                {tbl[i].gnt, tbl[i].wreq, tbl[i].rreq, tbl[i].done, tbl[i].err});
        end

        // Single write with address/len capture and input changes after grant.
        rstn = 0; cli_req = '0; wr_busy = 0; rd_busy = 0;
        step();
        chk("rst_out", {cli_gnt, cli_done, cli_err, wr_req, rd_req, wr_addr, rd_addr, wr_len, rd_len}, '0);
        rstn = 1; init_done = 1;
        cli_addr[0 +: AW] = AW'('h0000100); cli_len[0 +: LW] = 4'd7;
        cli_req = 4'b0001;
        step();
        chk("wr_grant", {cli_gnt, wr_req, rd_req, wr_addr, wr_len},
            {4'b0001, 1'b1, 1'b0, AW'('h0000100), 4'd7});
        chk("rd_hold", {rd_addr, rd_len}, '0);
        cli_req = '0; cli_addr[0 +: AW] = AW'('h0ABCDEF); cli_len[0 +: LW] = 4'd2;
        wr_busy = 1;
        step();
        chk("wr_ack", {cli_gnt, wr_req, wr_addr, wr_len},
            {4'b0001, 1'b0, AW'('h0000100), 4'd7});
        for (int i = 0; i < 7; i++) step();
        chk("wr_nodone", {cli_gnt, cli_done}, {4'b0001, 4'b0000});
        wr_busy = 0;
        step();
        chk("wr_done", {cli_gnt, cli_done}, {4'b0000, 4'b0001});
        step();
        chk("done_1cyc", cli_done, 4'b0000);

        // Read timeout with the controller never going busy.
        rstn = 0; step();
        rstn = 1; cli_req = 4'b0100; rd_busy = 0;
        step();
        chk("to_grant", {cli_gnt, rd_req, wr_req, rd_addr},
            {4'b0100, 1'b1, 1'b0, AW'('h300)});
        cli_req = '0;
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!rd_req) break;
            hi++;
        end
        chk("to_len", 128'(hi), 128'(TMO));
        chk("to_err", {cli_err, cli_gnt, cli_done}, {4'b0100, 4'b0000, 4'b0000});
        step();
        chk("to_err_1cyc", {cli_err, rd_req}, '0);

        // Reset while waiting for the read controller to finish.
        cli_req = 4'b1000;
        step();
        chk("rst_grant", {cli_gnt, rd_req}, {4'b1000, 1'b1});
        cli_req = '0; rd_busy = 1;
        step();
        chk("rst_wdone", {cli_gnt, rd_req}, {4'b1000, 1'b0});
        rstn = 0;
        step();
        chk("rst_mid", {cli_gnt, cli_done, cli_err, wr_req, rd_req, rd_addr, rd_len}, '0);
        rstn = 1; rd_busy = 0; cli_req = 4'b1111;
        step();
        chk("rst_prio", {cli_gnt, cli_done, cli_err}, {4'b0001, 4'b0000, 4'b0000});

        // Random traffic: busy controller phase, then timeout-heavy phase.
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 2500; n++) begin
                rstn      = ($urandom_range(0, 299) != 0);
                init_done = ($urandom_range(0, 9) != 0);
                cli_req   = 4'($urandom);
                cli_addr  = {$urandom, $urandom, $urandom, $urandom};
                cli_len   = 16'($urandom);
                wr_busy   = ($urandom_range(0, 99) < (ph == 0 ? 40 : 3));
                rd_busy   = ($urandom_range(0, 99) < (ph == 0 ? 40 : 3));
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
